byte_stream_packer: RTL and testbench
=====================================

Name: byte_stream_packer

Overview:
- Sequential receive-side counterpart to the word-level endian byte swap.
- Accepts a serial byte stream over valid/ready and assembles it into BYTES-wide words.
- Byte order (big- or little-endian lane placement) is selected per word.
- Sits between byte-serial transports (host/DMA link) and word-wide datapaths.
- Supports partial final words via in_last.

Parameters:
BYTES, 6, bytes per assembled word (>= 2); out_word width is 8*BYTES.
CW, $clog2(BYTES+1), width of the byte count fields (derived; do not override).

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_byte/in_last valid.
in_ready  output  1  packer accepts a byte this cycle.
in_byte  input  8  stream byte.
in_last  input  1  final byte of a message; closes the current word early.
cfg_little_endian  input  1  lane order, sampled with the first byte of each word.
out_valid  output  1  out_word/out_count valid.
out_ready  input  1  sink accepts the word.
out_word  output  8*BYTES  assembled word.
out_count  output  CW  number of valid bytes in out_word (1..BYTES).

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous and active-high (`reset`).
- Reset values:
  - out_valid=0, out_word=0, out_count=0.
  - Internal byte index idx=0, assembly register=0, latched order bit=0.
  - A reset asserted mid-word discards the partial word; no output is produced for it.
- Handshakes:
  - A byte transfers on a rising edge when in_valid && in_ready.
  - A word transfers when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational from out_ready; no other dependence).
- Lane placement for byte index i (0 = first byte received in the word):
  - Big-endian (latched bit 0): lane BYTES-1-i, i.e. bits [8*(BYTES-i)-1 -: 8].
  - Little-endian (latched bit 1): lane i.
- Order latching: cfg_little_endian is latched on the transfer with idx==0 and held for the rest of the word. Changes mid-word are ignored.
- Non-completing transfer (idx < BYTES-1 and !in_last):
  - Write the byte into its lane.
  - idx <= idx+1.
- Completing transfer (idx == BYTES-1 or in_last):
  - At the same edge, out_word <= assembly with the current byte merged in.
  - out_count <= idx+1, out_valid <= 1.
  - idx <= 0 and the assembly register clears to 0.
  - Latency: out_valid rises the cycle after the completing byte is accepted.
- Partial words: unfilled lanes are zero. Big-endian partials are left-justified (MS lanes); little-endian partials are right-justified.
- in_last on the byte at idx==BYTES-1 yields a normal full word (out_count=BYTES).
- in_last on the byte at idx==0 yields out_count=1.
- Output hold: while out_valid && !out_ready, out_word and out_count are stable and in_ready=0. The assembly register keeps accumulated bytes.
- Simultaneous drain and fill: if out_ready=1 and a completing byte transfers in the same cycle, the new word replaces the old one. out_valid stays 1, giving 1 byte/cycle sustained throughput.
- Drain only: a drain with no completing byte sets out_valid <= 0. out_word holds its last value (don't-care).
- in_valid=0 cycles are bubbles; idx does not change.

Test Plan:
- Full big-endian word:
  - Stimulus: cfg_little_endian=0; bytes aa,bb,cc,dd,ee,ff back-to-back; out_ready=1.
  - Required: out_word=48'haabbccddeeff, out_count=6, out_valid for exactly 1 cycle, asserted the cycle after ff is accepted.
- Full little-endian word:
  - Stimulus: same bytes with cfg_little_endian=1.
  - Required: out_word=48'hffeeddccbbaa, out_count=6.
- Partial words:
  - Stimulus: bytes 11,22,33 with in_last on 33.
  - Required (BE): out_word=48'h112233000000, out_count=3.
  - Required (LE): out_word=48'h000000332211.
  - Stimulus: single byte 5a with in_last at idx 0.
  - Required (BE): out_word=48'h5a0000000000, out_count=1.
- Backpressure:
  - Stimulus: two 6-byte words streamed back-to-back; out_ready=0 for 5 cycles after the first word.
  - Required: in_ready=0 only while the first word is held. The first word is stable throughout. The second word arrives intact with no byte loss or duplication. Once out_ready=1, one word per 6 cycles.
- Mid-word config change:
  - Stimulus: start BE; toggle cfg_little_endian to 1 after byte 2.
  - Required: whole word is BE. The next word picks up LE.
- Reset mid-word:
  - Stimulus: 3 bytes, assert reset asynchronously between clock edges, then release and send 6 bytes 01..06 (BE).
  - Required: immediately on reset, out_valid=0 and out_word=0. The next output is 48'h010203040506 with out_count=6.

Source files
------------

// File: rtl/byte_stream_packer.sv
// byte_stream_packer
// Receive-side packer: collects a valid/ready byte stream into BYTES-wide words.
// Each word's lane order (big/little endian) is latched with its first byte.
// in_last closes a word early, and unfilled lanes read as zero.
// The output register holds a word under backpressure. Simultaneous drain and
// refill keeps the packer at one byte per cycle.
module byte_stream_packer #(
  parameter int BYTES = 6,
  localparam int CW = $clog2(BYTES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  input  logic              cfg_little_endian,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*BYTES-1:0] out_word,
  output logic [CW-1:0]     out_count
);

  localparam int WW = 8 * BYTES;

  logic [CW-1:0] idx;
  logic [WW-1:0] assembly;
  logic          order_q;

  logic          xfer;
  logic          completing;
  logic          order_eff;
  logic [CW-1:0] lane;
  logic [WW-1:0] merged;

  // A new byte can enter whenever the output slot is empty or being drained now.
  assign in_ready = !out_valid || out_ready;

  // Pick the lane for the incoming byte and merge it into the partial word.
  // The first byte of a word uses the live order bit because that is the
  // moment the order gets latched.
  always_comb begin
    xfer       = in_valid && in_ready;
    completing = (idx == CW'(BYTES - 1)) || in_last;
    order_eff  = (idx == '0) ? cfg_little_endian : order_q;
    lane       = order_eff ? idx : (CW'(BYTES - 1) - idx);
    merged     = assembly | (WW'(in_byte) << {lane, 3'b000});
  end

  // Accumulate bytes and hand off completed words to the output register.
  // This also retires the output when the sink takes it without a replacement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      assembly  <= '0;
      order_q   <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer) begin
        if (idx == '0) begin
          order_q <= cfg_little_endian;
        end
        if (completing) begin
          out_word  <= merged;
          out_count <= idx + CW'(1);
          out_valid <= 1'b1;
          idx       <= '0;
          assembly  <= '0;
        end else begin
          assembly <= merged;
          idx      <= idx + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_stream_packer.sv
// tb_byte_stream_packer
// Self-checking bench for byte_stream_packer. The stimulus tasks feed bytes and
// record each word's expected value in a queue. A negedge monitor pops that
// queue on every output handshake and compares the word against the DUT. The
// monitor also checks hold stability and the in_ready rule.
module tb_byte_stream_packer;

  localparam int BYTES = 6;
  localparam int CW    = $clog2(BYTES + 1);
  localparam int WW    = 8 * BYTES;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_byte = 8'h00;
  logic          in_last = 1'b0;
  logic          cfg_little_endian = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_word;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  int ready_pct    = 100;
  int hold_cnt     = 0;
  int stall_cycles = 0;

  logic [WW-1:0]  exp_word_q[$];
  int             exp_count_q[$];
  logic [7:0]     cur_bytes[$];
  logic           cur_le = 1'b0;

  logic           held_prev = 1'b0;
  logic [WW-1:0]  held_word = '0;
  logic [CW-1:0]  held_count = '0;

  byte_stream_packer #(.BYTES(BYTES)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_byte(in_byte),
    .in_last(in_last),
    .cfg_little_endian(cfg_little_endian),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_count(out_count)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Sink behaviour: either a forced stall window or random readiness.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = (int'($urandom_range(99)) < ready_pct);
      end
    end
  end

  // Reference model. Every byte of a message goes into a list. When a word
  // closes, its bytes are placed by position: position i goes to lane i in
  // little-endian order, or to lane BYTES-1-i in big-endian order.
  task automatic model_accept(input logic [7:0] b, input logic last, input logic le);
    logic [WW-1:0] w;
    if (cur_bytes.size() == 0) cur_le = le;
    cur_bytes.push_back(b);
    if (last || cur_bytes.size() == BYTES) begin
      w = '0;
      foreach (cur_bytes[i]) begin
        if (cur_le) w[8*i +: 8] = cur_bytes[i];
        else        w[8*(BYTES-1-i) +: 8] = cur_bytes[i];
      end
      exp_word_q.push_back(w);
      exp_count_q.push_back(cur_bytes.size());
      cur_bytes.delete();
    end
  endtask

  // Offer one byte and keep it on the bus until the DUT accepts it.
  task automatic apply_stimulus(input logic [7:0] b, input logic last, input logic le);
    bit accepted;
    int waits;
    in_valid = 1'b1;
    in_byte = b;
    in_last = last;
    cfg_little_endian = le;
    accepted = 1'b0;
    waits = 0;
    while (!accepted && waits < 200) begin
      @(negedge clock);
      accepted = in_ready;
      @(posedge clock);
      #1;
      if (!accepted) begin
        waits++;
        stall_cycles++;
      end
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL accept_timeout byte=%h waited=%0d required=accepted", b, waits);
    end else begin
      model_accept(b, last, le);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Check the output register right after the edge that should have loaded it.
  task automatic check_output(input string name, input logic [WW-1:0] exp_w, input int exp_c);
    checks++;
    if (out_valid !== 1'b1 || out_word !== exp_w || out_count !== CW'(exp_c)) begin
      errors++;
      $display("[TB] FAIL %s got valid=%b word=%h count=%0d required valid=1 word=%h count=%0d",
               name, out_valid, out_word, out_count, exp_w, exp_c);
    end
  endtask

  // Compare a single-bit DUT output against an expected value.
  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%b required=%b", name, got, exp);
    end
  endtask

  // Compare an integer quantity against an expected value.
  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Let idle cycles pass with no byte offered.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Wait, with a cycle limit, until every expected word has been seen.
  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_word_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_int("drain_pending_words", exp_word_q.size(), 0);
  endtask

  // Monitor. It checks the in_ready rule on every cycle and checks that a held
  // word stays stable. On each handshake it compares the word against the
  // oldest expected word.
  always @(negedge clock) begin
    if (reset) begin
      held_prev <= 1'b0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("[TB] FAIL in_ready_rule got=%b required=%b", in_ready, (!out_valid || out_ready));
      end
      if (held_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_word !== held_word || out_count !== held_count) begin
          errors++;
          $display("[TB] FAIL hold_stable got valid=%b word=%h count=%0d required valid=1 word=%h count=%0d",
                   out_valid, out_word, out_count, held_word, held_count);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_word_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word got word=%h count=%0d required=none", out_word, out_count);
        end else begin
          logic [WW-1:0] ew;
          int ec;
          ew = exp_word_q.pop_front();
          ec = exp_count_q.pop_front();
          if (out_word !== ew || out_count !== CW'(ec)) begin
            errors++;
            $display("[TB] FAIL scoreboard_word got word=%h count=%0d required word=%h count=%0d",
                     out_word, out_count, ew, ec);
          end
        end
      end
      held_prev  <= out_valid && !out_ready;
      held_word  <= out_word;
      held_count <= out_count;
    end
  end

  // Main sequence: directed cases first, then a randomized stream.
  initial begin
    int stalls_before;
    logic [7:0] seq[6];
    seq[0] = 8'haa; seq[1] = 8'hbb; seq[2] = 8'hcc;
    seq[3] = 8'hdd; seq[4] = 8'hee; seq[5] = 8'hff;

    ready_pct = 100;
    repeat (3) @(posedge clock);
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_int("reset_out_word_zero", int'(out_word != '0), 0);
    check_int("reset_out_count", int'(out_count), 0);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] full big-endian word");
    stall_cycles = 0;
    for (int i = 0; i < BYTES; i++) apply_stimulus(seq[i], 1'b0, 1'b0);
    check_output("full_be", 48'haabbccddeeff, 6);
    idle(1);
    check_bit("full_be_one_cycle", out_valid, 1'b0);

    $display("[TB] full little-endian word");
    for (int i = 0; i < BYTES; i++) apply_stimulus(seq[i], 1'b0, 1'b1);
    check_output("full_le", 48'hffeeddccbbaa, 6);
    check_int("no_stall_streaming", stall_cycles, 0);

    $display("[TB] partial words");
    apply_stimulus(8'h11, 1'b0, 1'b0);
    apply_stimulus(8'h22, 1'b0, 1'b0);
    apply_stimulus(8'h33, 1'b1, 1'b0);
    check_output("partial_be", 48'h112233000000, 3);
    apply_stimulus(8'h11, 1'b0, 1'b1);
    apply_stimulus(8'h22, 1'b0, 1'b1);
    apply_stimulus(8'h33, 1'b1, 1'b1);
    check_output("partial_le", 48'h000000332211, 3);
    apply_stimulus(8'h5a, 1'b1, 1'b0);
    check_output("single_be", 48'h5a0000000000, 1);
    for (int i = 0; i < BYTES; i++) apply_stimulus(seq[i], (i == BYTES - 1), 1'b0);
    check_output("last_on_full", 48'haabbccddeeff, 6);

    $display("[TB] backpressure");
    idle(2);
    for (int i = 0; i < BYTES; i++) apply_stimulus(8'(8'h10 + i), 1'b0, 1'b0);
    hold_cnt = 5;
    stalls_before = stall_cycles;
    for (int i = 0; i < BYTES; i++) apply_stimulus(8'(8'h20 + i), 1'b0, 1'b0);
    check_int("backpressure_stalls", stall_cycles - stalls_before, 5);
    check_output("backpressure_second", 48'h202122232425, 6);

    $display("[TB] mid-word config change");
    for (int i = 0; i < BYTES; i++) apply_stimulus(8'(i + 1), 1'b0, (i >= 2));
    check_output("cfg_change_be", 48'h010203040506, 6);
    for (int i = 0; i < BYTES; i++) apply_stimulus(8'(i + 1), 1'b0, 1'b1);
    check_output("cfg_next_le", 48'h060504030201, 6);

    $display("[TB] reset mid-word");
    wait_drain();
    apply_stimulus(8'h77, 1'b0, 1'b0);
    apply_stimulus(8'h88, 1'b0, 1'b0);
    apply_stimulus(8'h99, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_bit("async_reset_out_valid", out_valid, 1'b0);
    check_int("async_reset_out_word_zero", int'(out_word != '0), 0);
    cur_bytes.delete();
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < BYTES; i++) apply_stimulus(8'(i + 1), 1'b0, 1'b0);
    check_output("after_reset_be", 48'h010203040506, 6);

    $display("[TB] randomized stream");
    ready_pct = 70;
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(8'($urandom), ($urandom_range(9) == 0), 1'($urandom));
      if ($urandom_range(3) == 0) idle(1);
    end
    apply_stimulus(8'($urandom), 1'b1, 1'($urandom));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
